// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: input synchronizers, edge ticks, PAUSE/RUN/ADJUST FSM, BCD count.
// Define STOPWATCH_BLINK_EN to compile the adjust-mode digit blanking.
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic       one_hz_clk,
    input  logic       two_hz_clk,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank,
    output logic [1:0] dbg_state   // 0 = PAUSE, 1 = RUN, 2 = ADJUST
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] MAX_SEC_BCD = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

    // Edge-detected inputs, bit order {clr, pause, two_hz, one_hz}.
    logic [3:0] w_edge_in;
    logic [3:0] r_edge_s1;
    logic [3:0] r_edge_s2;
    logic [3:0] r_edge_d;
    logic [3:0] r_tick;

    // Level-only inputs, bit order {sel, adj}.
    logic [1:0] w_lvl_in;
    logic [1:0] r_lvl_s1;
    logic [1:0] r_lvl_s2;

    logic w_tick1;
    logic w_tick2;
    logic w_pause_p;
    logic w_clr_p;
    logic w_adj;
    logic w_sel;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic       r_running;

    assign w_edge_in = {btn_clr, btn_pause, two_hz_clk, one_hz_clk};
    assign w_lvl_in  = {sw_sel, sw_adj};

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            r_edge_s1 <= '0;
            r_edge_s2 <= '0;
            r_edge_d  <= '0;
            r_tick    <= '0;
            r_lvl_s1  <= '0;
            r_lvl_s2  <= '0;
        end else begin
            r_edge_s1 <= w_edge_in;
            r_edge_s2 <= r_edge_s1;
            r_edge_d  <= r_edge_s2;
            r_tick    <= r_edge_s2 & ~r_edge_d;
            r_lvl_s1  <= w_lvl_in;
            r_lvl_s2  <= r_lvl_s1;
        end
    end

    assign w_tick1   = r_tick[0];
    assign w_tick2   = r_tick[1];
    assign w_pause_p = r_tick[2];
    assign w_clr_p   = r_tick[3];
    assign w_adj     = r_lvl_s2[0];
    assign w_sel     = r_lvl_s2[1];

    // Two-digit BCD increment that wraps to 00 after the field maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_bcd);
        logic [7:0] res;
        if (val == max_bcd) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            r_state   <= ST_PAUSE;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min     <= w_min_nxt;
            r_sec     <= w_sec_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // Clear outranks every transition; a transition or pause swallows a same-cycle tick.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        if (w_clr_p) begin
            w_min_nxt = 8'h00;
            w_sec_nxt = 8'h00;
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end
        end else begin
            case (r_state)
                ST_PAUSE: begin
                    if (w_adj) begin
                        w_state_nxt = ST_ADJUST;
                    end else if (w_pause_p) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_adj) begin
                        w_state_nxt = ST_ADJUST;
                    end else if (w_pause_p) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick1) begin
                        w_sec_nxt = bcd_inc(r_sec, MAX_SEC_BCD);
                        if (r_sec == MAX_SEC_BCD) begin
                            w_min_nxt = bcd_inc(r_min, MAX_MIN_BCD);
                        end
                    end
                end
                ST_ADJUST: begin
                    if (!w_adj) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick2) begin
                        if (w_sel) begin
                            w_sec_nxt = bcd_inc(r_sec, MAX_SEC_BCD);
                        end else begin
                            w_min_nxt = bcd_inc(r_min, MAX_MIN_BCD);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_PAUSE;
                end
            endcase
        end
    end

`ifdef STOPWATCH_BLINK_EN
    // Registered from the first sync stage so blank tracks the synced level in the same cycle.
    logic [3:0] r_blank;
    logic [3:0] w_blank_nxt;

    always_comb begin
        w_blank_nxt = 4'b0000;
        if (w_state_nxt == ST_ADJUST && r_edge_s1[1]) begin
            w_blank_nxt = r_lvl_s1[1] ? 4'b0011 : 4'b1100;
        end
    end

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            r_blank <= 4'b0000;
        end else begin
            r_blank <= w_blank_nxt;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 4'b0000;
`endif

    assign min_tens  = r_min[7:4];
    assign min_ones  = r_min[3:0];
    assign sec_tens  = r_sec[7:4];
    assign sec_ones  = r_sec[3:0];
    assign running   = r_running;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: scenario table, hand-written corner sequences, random stimulus vs model.
module tb_stopwatch_ctrl;

    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;
    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_ADJ   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       one_hz, two_hz, btn_pause, btn_clr, sw_adj, sw_sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [3:0] blank;
    logic [1:0] dbg_state;

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
        .master_clk (clk),
        .rst        (rst),
        .one_hz_clk (one_hz),
        .two_hz_clk (two_hz),
        .btn_pause  (btn_pause),
        .btn_clr    (btn_clr),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .blank      (blank),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Each input's effect lands a fixed number of sampled clock edges later; the
    // sample history (bits {sel, adj, clr, pause, two, one}) is that delay line.
    int         m_mode;
    int         m_mm, m_ss;
    logic [3:0] m_blank;
    logic [5:0] hist[4];

    function automatic int wrap_inc(input int v, input int max);
        return (v == max) ? 0 : v + 1;
    endfunction

    task automatic model_edge();
        logic [5:0] now;
        bit t1, t2, pp, cp, adj, sel;
        now = {sw_sel, sw_adj, btn_clr, btn_pause, two_hz, one_hz};
        if (!rst) begin
            m_mode = M_PAUSE;
            m_mm = 0;
            m_ss = 0;
            m_blank = 4'b0000;
            for (int i = 0; i < 4; i++) hist[i] = '0;
        end else begin
            t1  = hist[2][0] & ~hist[3][0];
            t2  = hist[2][1] & ~hist[3][1];
            pp  = hist[2][2] & ~hist[3][2];
            cp  = hist[2][3] & ~hist[3][3];
            adj = hist[1][4];
            sel = hist[1][5];
            if (cp) begin
                m_mm = 0;
                m_ss = 0;
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (m_mode == M_PAUSE) begin
                if (adj) m_mode = M_ADJ;
                else if (pp) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (adj) m_mode = M_ADJ;
                else if (pp) m_mode = M_PAUSE;
                else if (t1) begin
                    if (m_ss == MAX_SEC) m_mm = wrap_inc(m_mm, MAX_MIN);
                    m_ss = wrap_inc(m_ss, MAX_SEC);
                end
            end else begin
                if (!adj) m_mode = M_PAUSE;
                else if (t2) begin
                    if (sel) m_ss = wrap_inc(m_ss, MAX_SEC);
                    else m_mm = wrap_inc(m_mm, MAX_MIN);
                end
            end
            m_blank = 4'b0000;
`ifdef STOPWATCH_BLINK_EN
            if (m_mode == M_ADJ && hist[0][1]) m_blank = hist[0][5] ? 4'b0011 : 4'b1100;
`endif
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = now;
        end
    endtask

    function automatic logic [15:0] bcd_of(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_count", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(bcd_of(m_mm, m_ss)));
        check("model_running", 32'(running), 32'(m_mode == M_RUN));
        check("model_blank", 32'(blank), 32'(m_blank));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_one(input int n);
        repeat (n) begin
            one_hz = 1'b1; run(3);
            one_hz = 1'b0; run(3);
        end
    endtask

    task automatic pulse_two(input int n);
        repeat (n) begin
            two_hz = 1'b1; run(3);
            two_hz = 1'b0; run(3);
        end
    endtask

    typedef struct {
        bit adj;
        bit sel;
        bit pause;
        bit clr;
        int n_one;
        int n_two;
        int mm;
        int ss;
        bit run;
    } row_t;

    row_t tbl[20];

    task automatic apply_row(input int idx, input row_t r);
        sw_adj = r.adj;
        sw_sel = r.sel;
        run(4);
        if (r.pause) begin
            btn_pause = 1'b1; run(4);
            btn_pause = 1'b0; run(4);
        end
        if (r.clr) begin
            btn_clr = 1'b1; run(4);
            btn_clr = 1'b0; run(4);
        end
        pulse_one(r.n_one);
        pulse_two(r.n_two);
        run(6);
        check($sformatf("row%0d_count", idx), 32'({min_tens, min_ones, sec_tens, sec_ones}),
              32'(bcd_of(r.mm, r.ss)));
        check($sformatf("row%0d_running", idx), 32'(running), 32'(r.run));
    endtask

    logic [3:0] exp_blink_hi;

    initial begin
        //           adj sel pau clr one two  mm  ss  run
        tbl[0]  = '{0, 0, 1, 0,  0,  0,  0,  0, 1};
        tbl[1]  = '{0, 0, 0, 0, 61,  0,  1,  1, 1};
        tbl[2]  = '{1, 0, 0, 0,  0, 58, 59,  1, 0};
        tbl[3]  = '{1, 1, 0, 0,  0, 57, 59, 58, 0};
        tbl[4]  = '{0, 1, 0, 0,  0,  0, 59, 58, 0};
        tbl[5]  = '{0, 0, 1, 0,  0,  0, 59, 58, 1};
        tbl[6]  = '{0, 0, 0, 0,  1,  0, 59, 59, 1};
        tbl[7]  = '{0, 0, 0, 0,  1,  0,  0,  0, 1};
        tbl[8]  = '{0, 0, 0, 0, 58,  0,  0, 58, 1};
        tbl[9]  = '{1, 1, 0, 0,  0,  3,  0,  1, 0};
        tbl[10] = '{1, 0, 0, 0,  0,  2,  2,  1, 0};
        tbl[11] = '{1, 0, 0, 0,  5,  0,  2,  1, 0};
        tbl[12] = '{1, 0, 1, 0,  0,  0,  2,  1, 0};
        tbl[13] = '{0, 0, 0, 0,  0,  0,  2,  1, 0};
        tbl[14] = '{0, 0, 0, 0,  3,  0,  2,  1, 0};
        tbl[15] = '{0, 0, 1, 0,  0,  0,  2,  1, 1};
        tbl[16] = '{0, 0, 0, 0,  2,  0,  2,  3, 1};
        tbl[17] = '{0, 0, 0, 1,  0,  0,  0,  0, 0};
        tbl[18] = '{1, 0, 0, 1,  0,  0,  0,  0, 0};
        tbl[19] = '{0, 0, 1, 0,  0,  0,  0,  0, 1};

`ifdef STOPWATCH_BLINK_EN
        exp_blink_hi = 4'b1100;
`else
        exp_blink_hi = 4'b0000;
`endif

        rst = 1'b0;
        one_hz = 1'b0; two_hz = 1'b0; btn_pause = 1'b0; btn_clr = 1'b0;
        sw_adj = 1'b0; sw_sel = 1'b0;

        // Reset state.
        run(3);
        check("reset_count", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_blank", 32'(blank), 32'h0);
        rst = 1'b1;
        run(2);

        for (int i = 0; i < 20; i++) apply_row(i, tbl[i]);

        // First increment lands on the fourth edge after the input rises; wide high gives one tick.
        one_hz = 1'b1;
        step(); check("lat_c1", 32'(sec_ones), 32'd0);
        step(); check("lat_c2", 32'(sec_ones), 32'd0);
        step(); check("lat_c3", 32'(sec_ones), 32'd0);
        step(); check("lat_c4", 32'(sec_ones), 32'd1);
        run(10);
        check("tick_width", 32'(sec_ones), 32'd1);
        one_hz = 1'b0;
        run(6);

        // Clear and a seconds tick in the same cycle.
        btn_clr = 1'b1; one_hz = 1'b1;
        run(4);
        btn_clr = 1'b0; one_hz = 1'b0;
        run(6);
        check("clr_prio_count", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
        check("clr_prio_running", 32'(running), 32'h0);

        // Held pause button toggles once.
        btn_pause = 1'b1;
        run(20);
        check("held_pause", 32'(running), 32'h1);
        btn_pause = 1'b0;
        run(6);
        check("held_pause_release", 32'(running), 32'h1);

        // Blink in ADJUST with minutes selected.
        sw_adj = 1'b1; sw_sel = 1'b0;
        run(4);
        two_hz = 1'b1;
        run(4);
        check("blink_hi", 32'(blank), 32'(exp_blink_hi));
        two_hz = 1'b0;
        run(4);
        check("blink_lo", 32'(blank), 32'h0);

        // Set 12:34 in ADJUST, then reset for one cycle with sw_adj still high.
        pulse_two(11);
        sw_sel = 1'b1;
        run(4);
        pulse_two(34);
        run(6);
        check("adj_1234", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h1234);
        rst = 1'b0;
        step();
        check("rst_mid_count", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
        check("rst_mid_running", 32'(running), 32'h0);
        check("rst_mid_blank", 32'(blank), 32'h0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        step();
        step();
        check("readj_c2_state", 32'(dbg_state), 32'd0);
        step();
        check("readj_c3_state", 32'(dbg_state), 32'd2);

        // Random stimulus against the model.
        repeat (4000) begin
            if ($urandom_range(3) == 0)  one_hz    = ~one_hz;
            if ($urandom_range(3) == 0)  two_hz    = ~two_hz;
            if ($urandom_range(15) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(59) == 0) btn_clr   = ~btn_clr;
            if ($urandom_range(79) == 0) sw_adj    = ~sw_adj;
            if ($urandom_range(19) == 0) sw_sel    = ~sw_sel;
            rst = ($urandom_range(299) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the lab3 stopwatch. It sits between `clk_divider` and the 7-segment display driver. The block samples the divided clocks (`one_hz_clk`, `two_hz_clk`) and the user controls in the `master_clk` domain, then runs a RUN/PAUSE/ADJUST state machine. It holds the MM:SS count in BCD and produces per-digit blank flags for adjust-mode blinking.

## Interface
- `MAX_MIN`, default 59: highest minutes value; minutes wrap to 0 after it.
- `MAX_SEC`, default 59: highest seconds value; seconds wrap to 0 after it.
- `master_clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `one_hz_clk` in 1: 1 Hz divided clock from `clk_divider`; level input.
- `two_hz_clk` in 1: 2 Hz divided clock; level input.
- `btn_pause` in 1: debounced pause button, level; acts on its rising edge.
- `btn_clr` in 1: debounced clear button, level; acts on its rising edge.
- `sw_adj` in 1: 1 = adjust mode.
- `sw_sel` in 1: adjust field select; 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: BCD count.
- `running` out 1: 1 while in RUN.
- `blank` out 4: per-digit blank, in order {min_tens, min_ones, sec_tens, sec_ones}; 1 = blank.

## Operation
- **Input sampling.** `one_hz_clk`, `two_hz_clk`, `btn_pause`, `btn_clr` and `sw_adj`/`sw_sel` each pass through a 2-flop synchronizer.
- **Edge ticks.** A rising-edge detector on each synced signal gives one-cycle ticks: `tick1`, `tick2`, `pause_p`, `clr_p`.
- **States.** PAUSE (the reset state), RUN, ADJUST.
- **PAUSE.**
  - `pause_p` → RUN.
  - synced `sw_adj` = 1 → ADJUST.
- **RUN.**
  - `tick1` increments seconds.
  - If seconds = MAX_SEC, seconds → 0 and minutes increment.
  - If minutes = MAX_MIN at that carry, minutes → 0 (59:59 → 00:00).
  - `pause_p` → PAUSE.
  - synced `sw_adj` = 1 → ADJUST.
- **ADJUST.**
  - The normal count is frozen.
  - On `tick2`, the selected field increments by 1 and wraps at its MAX to 0, with no carry into the other field.
  - `pause_p` is ignored.
  - synced `sw_adj` = 0 → PAUSE.
- **Clear.** `clr_p` clears the count to 00:00 in any state. The state is unchanged, except RUN → PAUSE.
- **Priority within one cycle:** reset > `clr_p` > `sw_adj` transition > `pause_p` > tick increment.
  - A `tick1` that coincides with `pause_p` is dropped.
  - A tick that coincides with `clr_p` is dropped.
- **Arithmetic.** Counters are held as two BCD digits per field. An ones digit of 9 rolls to 0 and increments tens. Values above MAX are never reachable.

## Timing
- **Reset.** While `rst` = 0 at a clock edge:
  - state → PAUSE;
  - all count digits 0;
  - `running` 0;
  - `blank` 4'b0000;
  - synchronizer and edge flops 0.
- **Edge-to-tick latency.** A rising input edge gives a tick 3 `master_clk` cycles later: 2 sync stages plus 1 edge register. The count outputs update on the following edge, 4 cycles total.
- **Output timing.** All outputs are registered. `running` changes in the same cycle as the state register.
- **Tick width.** Each tick is exactly one cycle wide, regardless of how long the input stays high.
- **Pulses after reset.** The edge registers are cleared at reset. An input already high when reset releases produces one tick 3 cycles after release.
- **Reset mid-operation.** Takes effect on the next edge with `rst` = 0. No partial increment survives.
- **sw_sel changes in ADJUST.** Take effect at the synced value. No increment is generated by a select change itself.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - In ADJUST, the selected field's two `blank` bits equal the synced `two_hz_clk` level: blank while high, shown while low.
  - The other bits are 0.
- `STOPWATCH_BLINK_EN` undefined:
  - `blank` is constant 4'b0000 in all states.
  - The blink logic is not compiled.

## Test plan
- **Reset and run.** Hold `rst`=0 for 3 cycles, release, pulse `btn_pause`, apply 61 `one_hz_clk` rising edges → count 01:01, `running`=1, first increment 4 cycles after the first edge.
- **Full wrap.** Start from 59:58 in RUN, apply 2 edges → 59:59 then 00:00. Minutes wrap without any out-of-range value.
- **Adjust.** `sw_adj`=1, `sw_sel`=1 at 00:58, apply 3 `two_hz_clk` edges → 00:01 with minutes unchanged. Then `sw_sel`=0 and 2 edges → 02:01. Concurrent `one_hz_clk` edges have no effect.
- **Clear priority.** In RUN, `btn_clr` and `one_hz_clk` rise in the same cycle → 00:00, state PAUSE, `running`=0. A held `btn_pause` toggles only once.
- **Blink.** With `STOPWATCH_BLINK_EN`, ADJUST and `sw_sel`=0: `blank` = 4'b1100 while synced `two_hz_clk`=1, 4'b0000 while low. Without the macro, `blank` stays 4'b0000.
- **Reset mid-adjust.** In ADJUST at 12:34, drive `rst`=0 for 1 cycle → 00:00, PAUSE, `blank`=0. The block re-enters ADJUST 3 cycles after release because `sw_adj` is still 1.
